// File: rtl/bcd_digit_streamer.sv
// rtl/bcd_digit_streamer.sv - NDIG-digit BCD event counter with snapshot-and-stream digit port
module bcd_digit_streamer #(
    parameter int NDIG = 4,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            clr,
    input  logic            start,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [3:0]      out_digit,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            busy,
    output logic            ovf
);

    localparam int W = NDIG * 4;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [W-1:0]    cnt;
    logic [W-1:0]    cnt_inc;
    logic [W-1:0]    shadow;
    logic            all_nine;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] idx_nxt;

    // Ripple-carry BCD increment; the final carry means every digit was 9.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        cnt_inc = cnt;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (cnt[i*4 +: 4] == 4'd9) begin
                    cnt_inc[i*4 +: 4] = 4'd0;
                end else begin
                    cnt_inc[i*4 +: 4] = cnt[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all_nine = carry;
    end

    assign idx_nxt = idx + IDXW'(1);
    assign out_idx = idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            shadow    <= '0;
            idx       <= '0;
            state     <= IDLE;
            out_valid <= 1'b0;
            out_digit <= 4'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt_inc;
            end
            ovf <= inc & ~clr & all_nine;

            case (state)
                IDLE: begin
                    if (start) begin
                        shadow    <= cnt;
                        idx       <= '0;
                        state     <= SEND;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_digit <= cnt[3:0];
                        out_last  <= (NDIG == 1);
                    end
                end
                SEND: begin
                    // Without a transfer every output register simply holds.
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
                            out_digit <= 4'd0;
                            idx       <= '0;
                        end else begin
                            idx       <= idx_nxt;
                            out_digit <= shadow[{idx_nxt, 2'b00} +: 4];
                            out_last  <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
